sa_obi_if: RTL and testbench
============================

SA_OBI_IF -- requirements
Module: sa_obi_if

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of OBI data and of both stream payloads.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, entry count of each FIFO (power of two, minimum 2).
REQ-003 The block SHALL have the following ports; the bus side is the X-HEEP external-crossbar OBI slave, the stream side feeds and drains the systolic array:
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables (ignored)
- wdata_i  in  DATA_W  write data
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_W  read data
- in_valid_o  out  1  array input stream valid
- in_last_o  out  1  tag: 1 = weight word, 0 = activation word
- in_data_o  out  DATA_W  array input payload
- in_ready_i  in  1  array accepts input
- out_valid_i  in  1  array result valid
- out_data_i  in  DATA_W  array result payload
- out_ready_o  out  1  block accepts result

Function
REQ-004 Register map, decoded from addr_i[4:2]:
- 0x00 CTRL: RW; bit0 clear (self-clearing)
- 0x04 STATUS: RO; in-FIFO level [7:0], out-FIFO level [15:8]
- 0x08 WEIGHT: WO; push {tag=1, wdata}
- 0x0C ACT: WO; push {tag=0, wdata}
- 0x10 RESULT: RO; pop
REQ-005 gnt_o SHALL be combinational: 1 when req_i is high, except a WEIGHT/ACT write with a full in-FIFO, or a RESULT read with an empty out-FIFO; both stall until space/data exists.
REQ-006 rvalid_o SHALL assert exactly one cycle after each granted request, for reads and writes alike; rdata_o SHALL be registered and 0 for writes.
REQ-007 Unmapped offsets and reads of write-only registers SHALL be granted immediately, SHALL return 0 and SHALL have no side effect.
REQ-008 The in-FIFO SHALL drive in_valid_o/in_last_o/in_data_o from its head; it pops when in_valid_o and in_ready_i are both high.
REQ-009 out_ready_o SHALL equal NOT out-FIFO full; the out-FIFO pushes when out_valid_i and out_ready_o are both high.
REQ-010 A simultaneous push and pop on a full FIFO SHALL be permitted only when the pop is stream-side (in-FIFO); a simultaneous push and pop on an empty out-FIFO is not possible (gnt stalls).
REQ-011 Pointers SHALL wrap modulo FIFO_DEPTH; levels SHALL count 0..FIFO_DEPTH with no overflow or underflow.
REQ-012 Writing CTRL.clear=1 SHALL empty both FIFOs in the cycle after grant; a stream handshake in that same cycle SHALL be discarded.
REQ-013 Response state SHALL form a two-state machine: IDLE -> RESP on grant; RESP -> RESP on back-to-back grant, otherwise RESP -> IDLE.

Reset
REQ-014 While rst_i is high at a clk_i edge: FIFOs empty, state IDLE, rvalid_o=0, rdata_o=0, in_valid_o=0, out_ready_o=1 (after release), gnt_o=0.
REQ-015 A reset asserted mid-transaction SHALL drop the pending response without emitting rvalid_o.

Configuration
REQ-016 With SA_OBI_IF_PERF_CNT_EN defined, the block SHALL add a 32-bit RO register CYCLES at 0x14. CYCLES counts cycles with in_valid_o & !in_ready_i, saturates at all-ones, and is zeroed by reset or CTRL.clear.
REQ-017 Without SA_OBI_IF_PERF_CNT_EN, offset 0x14 SHALL behave as unmapped and the counter SHALL not exist.

Structure
REQ-018 Register offsets, STATUS field positions and the FIFO entry struct {tag, data} SHALL reside in heepstor_pkg.
REQ-019 Both FIFOs SHALL be instances of one sub-module, sa_sync_fifo, parameterised by width and depth.

Verification
REQ-020 Write 0x08=0xA5A5A5A5, then 0x0C=0x00000011, with in_ready_i=1 -> stream shows (last=1,0xA5A5A5A5) then (last=0,0x11); rvalid_o one cycle after each grant.
REQ-021 With in_ready_i=0, perform 5 ACT writes at depth 4 -> four granted, fifth gnt_o=0 until one in_ready_i pulse, then granted; STATUS[7:0] reads 4.
REQ-022 Read RESULT with an empty out-FIFO -> gnt_o=0; drive out_valid_i with 0x1234 -> grant the following cycle, rdata_o=0x1234.
REQ-023 Fill the out-FIFO to 4 entries -> out_ready_o=0; write CTRL=1 -> STATUS reads 0 and out_ready_o=1.
REQ-024 Read offset 0x1C -> immediate grant, rdata_o=0; with the macro, stall 10 cycles and read 0x14 -> 10; without the macro, 0x14 reads 0.
REQ-025 Assert rst_i the cycle after a grant -> no rvalid_o, FIFOs empty.

Source files
------------

// File: rtl/heepstor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heepstor_pkg
// Brief    : Register map, STATUS layout and FIFO entry type for sa_obi_if.
// Revision : 1.0
// ============================================================================
package heepstor_pkg;

    // Widest payload the in-FIFO entry can carry; DATA_W must not exceed it.
    localparam int SA_DATA_W = 32;

    // Byte offsets; the block decodes bits [4:2].
    localparam logic [4:0] OFS_CTRL   = 5'h00;
    localparam logic [4:0] OFS_STATUS = 5'h04;
    localparam logic [4:0] OFS_WEIGHT = 5'h08;
    localparam logic [4:0] OFS_ACT    = 5'h0C;
    localparam logic [4:0] OFS_RESULT = 5'h10;
    localparam logic [4:0] OFS_CYCLES = 5'h14;

    localparam int CTRL_CLEAR_BIT     = 0;
    localparam int STATUS_LVL_W       = 8;
    localparam int STATUS_IN_LVL_LSB  = 0;
    localparam int STATUS_OUT_LVL_LSB = 8;

    typedef struct packed {
        logic                 tag;
        logic [SA_DATA_W-1:0] data;
    } sa_fifo_entry_t;

    function automatic logic [31:0] pack_status(input logic [STATUS_LVL_W-1:0] in_lvl,
                                                input logic [STATUS_LVL_W-1:0] out_lvl);
        logic [31:0] v;
        v = '0;
        v[STATUS_IN_LVL_LSB  +: STATUS_LVL_W] = in_lvl;
        v[STATUS_OUT_LVL_LSB +: STATUS_LVL_W] = out_lvl;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sa_sync_fifo
// Brief    : Single-clock FIFO with level output and synchronous clear.
// Revision : 1.0
// ============================================================================
module sa_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o  = (r_level == LW'(DEPTH));
    assign empty_o = (r_level == '0);
    assign level_o = r_level;
    assign rdata_o = r_mem[r_rptr];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push && !clr_i) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sa_obi_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_obi_if
// Brief    : OBI slave feeding/draining a systolic array through two FIFOs.
//            Optional CYCLES stall counter: define SA_OBI_IF_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module sa_obi_if
    import heepstor_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              in_valid_o,
    output logic              in_last_o,
    output logic [DATA_W-1:0] in_data_o,
    input  logic              in_ready_i,
    input  logic              out_valid_i,
    input  logic [DATA_W-1:0] out_data_i,
    output logic              out_ready_o
);
    localparam int         LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int         ENTRY_W = $bits(sa_fifo_entry_t);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [2:0]        w_sel;
    logic              w_is_push;
    logic              w_is_pop;
    logic              w_grant;
    logic              w_clear;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_out_full;
    logic              w_out_empty;
    logic [LVL_W-1:0]  w_in_level;
    logic [LVL_W-1:0]  w_out_level;
    sa_fifo_entry_t    w_in_wentry;
    sa_fifo_entry_t    w_in_head;
    logic [DATA_W-1:0] w_out_head;
    logic [DATA_W-1:0] w_rd_value;
    logic [DATA_W-1:0] r_rdata;
    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic              w_unused_bits;

`ifdef SA_OBI_IF_PERF_CNT_EN
    logic [31:0]       r_cycles;
`endif

    assign w_unused_bits = ^{addr_i[31:5], addr_i[1:0], be_i};

    assign w_sel     = addr_i[4:2];
    assign w_is_push = we_i && ((w_sel == OFS_WEIGHT[4:2]) || (w_sel == OFS_ACT[4:2]));
    assign w_is_pop  = !we_i && (w_sel == OFS_RESULT[4:2]);

    // Stall only on push-to-full or pop-from-empty; everything else is granted at once.
    assign gnt_o   = req_i && !rst_i
                     && !(w_is_push && w_in_full)
                     && !(w_is_pop && w_out_empty);
    assign w_grant = gnt_o;
    assign w_clear = w_grant && we_i && (w_sel == OFS_CTRL[4:2]) && wdata_i[CTRL_CLEAR_BIT];

    assign w_in_wentry.tag  = (w_sel == OFS_WEIGHT[4:2]);
    assign w_in_wentry.data = SA_DATA_W'(wdata_i);

    sa_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clear),
        .push_i  (w_grant && w_is_push),
        .wdata_i (w_in_wentry),
        .pop_i   (in_valid_o && in_ready_i),
        .rdata_o (w_in_head),
        .full_o  (w_in_full),
        .empty_o (w_in_empty),
        .level_o (w_in_level)
    );

    sa_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clear),
        .push_i  (out_valid_i && out_ready_o),
        .wdata_i (out_data_i),
        .pop_i   (w_grant && w_is_pop),
        .rdata_o (w_out_head),
        .full_o  (w_out_full),
        .empty_o (w_out_empty),
        .level_o (w_out_level)
    );

    assign in_valid_o  = !w_in_empty;
    assign in_last_o   = w_in_head.tag;
    assign in_data_o   = w_in_head.data[DATA_W-1:0];
    assign out_ready_o = !w_out_full;

`ifdef SA_OBI_IF_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_cycles <= '0;
        end else if (in_valid_o && !in_ready_i && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rd_value = '0;
        case (w_sel)
            OFS_STATUS[4:2]: w_rd_value = DATA_W'(pack_status(STATUS_LVL_W'(w_in_level),
                                                              STATUS_LVL_W'(w_out_level)));
            OFS_RESULT[4:2]: w_rd_value = w_out_head;
`ifdef SA_OBI_IF_PERF_CNT_EN
            OFS_CYCLES[4:2]: w_rd_value = DATA_W'(r_cycles);
`endif
            default:         w_rd_value = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (w_grant && !we_i) begin
            r_rdata <= w_rd_value;
        end else begin
            r_rdata <= '0;
        end
    end

    assign rdata_o = r_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_next = w_grant ? ST_RESP : ST_IDLE;
            ST_RESP: w_state_next = w_grant ? ST_RESP : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Masking with reset drops a response whose reset arrives in the response cycle.
    always_comb begin
        rvalid_o = (r_state == ST_RESP) && !rst_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_obi_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_obi_if
// Brief    : Directed self-checking bench for sa_obi_if (depth 4, 32-bit data).
// Revision : 1.0
// ============================================================================
module tb_sa_obi_if;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_STATUS   = 32'h04;
    localparam logic [31:0] A_WEIGHT   = 32'h08;
    localparam logic [31:0] A_ACT      = 32'h0C;
    localparam logic [31:0] A_RESULT   = 32'h10;
    localparam logic [31:0] A_CYCLES   = 32'h14;
    localparam logic [31:0] A_UNMAPPED = 32'h1C;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        req_i       = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i      = '0;
    logic        we_i        = 1'b0;
    logic [3:0]  be_i        = 4'hF;
    logic [31:0] wdata_i     = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        in_valid_o;
    logic        in_last_o;
    logic [31:0] in_data_o;
    logic        in_ready_i  = 1'b0;
    logic        out_valid_i = 1'b0;
    logic [31:0] out_data_i  = '0;
    logic        out_ready_o;

    int n_checks = 0;
    int n_errors = 0;

    sa_obi_if #(
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .in_valid_o  (in_valid_o),
        .in_last_o   (in_last_o),
        .in_data_o   (in_data_o),
        .in_ready_i  (in_ready_i),
        .out_valid_i (out_valid_i),
        .out_data_i  (out_data_i),
        .out_ready_o (out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One OBI transfer; returns the response data and the number of stalled cycles.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int stalls);
        stalls  = 0;
        rd      = '0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        #1;
        while (gnt_o !== 1'b1 && stalls < 50) begin
            @(posedge clk_i);
            #2;
            stalls++;
        end
        if (gnt_o !== 1'b1) begin
            check("bus_grant_timeout", {63'd0, gnt_o}, 64'd1);
            req_i = 1'b0;
            we_i  = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
        check("rvalid_after_grant", {63'd0, rvalid_o}, 64'd1);
        rd = rdata_o;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          st;
        logic [31:0] exp_cycles;

        // Reset with a pending request: no grant, no response, streams idle.
        rst_i  = 1'b1;
        req_i  = 1'b1;
        addr_i = A_STATUS;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_in_valid", in_valid_o, 0);
        req_i = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_out_ready", out_ready_o, 1);
        check("idle_rvalid", rvalid_o, 0);

        // Weight then activation streamed with the array always ready.
        in_ready_i = 1'b1;
        bus(1'b1, A_WEIGHT, 32'hA5A5A5A5, d, st);
        check("weight_stall", st, 0);
        check("weight_rdata_zero", rdata_o, 0);
        check("s1_valid", in_valid_o, 1);
        check("s1_last", in_last_o, 1);
        check("s1_data", in_data_o, 32'hA5A5A5A5);
        bus(1'b1, A_ACT, 32'h00000011, d, st);
        check("s2_valid", in_valid_o, 1);
        check("s2_last", in_last_o, 0);
        check("s2_data", in_data_o, 32'h11);
        @(posedge clk_i);
        #1;
        check("stream_drained", in_valid_o, 0);
        check("rvalid_one_cycle", rvalid_o, 0);
        in_ready_i = 1'b0;

        // Fill the in-FIFO, fifth write stalls until one stream pop.
        for (int i = 1; i <= 4; i++) begin
            bus(1'b1, A_ACT, 32'(i), d, st);
            check("act_fill_stall", st, 0);
        end
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = A_ACT;
        wdata_i = 32'd5;
        #1;
        check("full_gnt0", gnt_o, 0);
        @(posedge clk_i);
        #2;
        check("full_gnt0_hold", gnt_o, 0);
        in_ready_i = 1'b1;
        #1;
        check("full_gnt0_during_pop", gnt_o, 0);
        @(posedge clk_i);
        #1;
        in_ready_i = 1'b0;
        #1;
        check("full_gnt_after_pop", gnt_o, 1);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
        check("fifth_rvalid", rvalid_o, 1);
        check("head_after_pop", in_data_o, 2);
        bus(1'b0, A_STATUS, 0, d, st);
        check("status_in4", d, 32'h0000_0004);
        in_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("drain_order", in_data_o, 32'(i));
            @(posedge clk_i);
            #1;
        end
        in_ready_i = 1'b0;
        check("drain_empty", in_valid_o, 0);

        // RESULT read on empty out-FIFO stalls until a result arrives.
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = A_RESULT;
        #1;
        check("res_empty_gnt0", gnt_o, 0);
        @(posedge clk_i);
        #2;
        check("res_empty_hold", gnt_o, 0);
        out_valid_i = 1'b1;
        out_data_i  = 32'h1234;
        #1;
        check("res_push_cycle_gnt0", gnt_o, 0);
        @(posedge clk_i);
        #1;
        out_valid_i = 1'b0;
        #1;
        check("res_gnt", gnt_o, 1);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check("res_rvalid", rvalid_o, 1);
        check("res_rdata", rdata_o, 32'h1234);

        // Fill out-FIFO, confirm backpressure and ordering, then clear both FIFOs.
        for (int i = 0; i < 4; i++) begin
            check("out_ready_fill", out_ready_o, 1);
            out_valid_i = 1'b1;
            out_data_i  = 32'h100 + 32'(i);
            @(posedge clk_i);
            #1;
        end
        out_valid_i = 1'b0;
        check("out_full_ready0", out_ready_o, 0);
        out_valid_i = 1'b1;
        out_data_i  = 32'hDEAD;
        @(posedge clk_i);
        #1;
        out_valid_i = 1'b0;
        bus(1'b0, A_STATUS, 0, d, st);
        check("status_out4", d, 32'h0000_0400);
        bus(1'b0, A_RESULT, 0, d, st);
        check("res_order0_stall", st, 0);
        check("res_order0", d, 32'h100);
        bus(1'b0, A_RESULT, 0, d, st);
        check("res_order1", d, 32'h101);
        bus(1'b1, A_ACT, 32'h77, d, st);
        bus(1'b0, A_STATUS, 0, d, st);
        check("status_both", d, 32'h0000_0201);
        bus(1'b1, A_CTRL, 32'h1, d, st);
        bus(1'b0, A_STATUS, 0, d, st);
        check("status_after_clear", d, 0);
        check("out_ready_after_clear", out_ready_o, 1);
        check("in_valid_after_clear", in_valid_o, 0);
        bus(1'b0, A_CTRL, 0, d, st);
        check("ctrl_self_clear", d, 0);

        // Unmapped and write-only reads.
        bus(1'b0, A_UNMAPPED, 0, d, st);
        check("unmapped_stall", st, 0);
        check("unmapped_rdata", d, 0);
        bus(1'b0, A_WEIGHT, 0, d, st);
        check("wo_read_rdata", d, 0);
        bus(1'b0, A_STATUS, 0, d, st);
        check("wo_read_no_effect", d, 0);

        // Ten stalled stream cycles, then read CYCLES.
        bus(1'b1, A_ACT, 32'h99, d, st);
        repeat (10) @(posedge clk_i);
        #1;
        bus(1'b0, A_CYCLES, 0, d, st);
`ifdef SA_OBI_IF_PERF_CNT_EN
        exp_cycles = 32'd10;
`else
        exp_cycles = 32'd0;
`endif
        check("cycles_after_stall", d, exp_cycles);
        bus(1'b1, A_CTRL, 32'h1, d, st);
        bus(1'b0, A_CYCLES, 0, d, st);
        check("cycles_after_clear", d, 0);

        // Reset in the response cycle drops the response and empties the FIFOs.
        bus(1'b1, A_ACT, 32'h55, d, st);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = A_ACT;
        wdata_i = 32'h66;
        #1;
        check("pre_rst_gnt", gnt_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        req_i = 1'b0;
        we_i  = 1'b0;
        #1;
        check("rst_drop_rvalid", rvalid_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_in_empty", in_valid_o, 0);
        check("rst_rvalid_after", rvalid_o, 0);
        bus(1'b0, A_STATUS, 0, d, st);
        check("rst_status_zero", d, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
